// File: rtl/cpu_main_memory_if.sv
// cpu_main_memory_if: cache-to-memory request/response bundle; mem_rsp_error exists only with CPU_MEM_RANGE_CHECK_EN
interface cpu_main_memory_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  mem_req_read;
  logic                  mem_req_write;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic [LINE_WIDTH-1:0] mem_req_data;
  logic                  mem_req_ready;
  logic                  mem_rsp_valid;
  logic [ADDR_WIDTH-1:0] mem_rsp_addr;
  logic [LINE_WIDTH-1:0] mem_rsp_data;
`ifdef CPU_MEM_RANGE_CHECK_EN
  logic                  mem_rsp_error;
  modport master (output mem_req_read, mem_req_write, mem_req_addr, mem_req_data,
                  input mem_req_ready, mem_rsp_valid, mem_rsp_addr, mem_rsp_data, mem_rsp_error);
  modport slave  (input mem_req_read, mem_req_write, mem_req_addr, mem_req_data,
                  output mem_req_ready, mem_rsp_valid, mem_rsp_addr, mem_rsp_data, mem_rsp_error);
`else
  modport master (output mem_req_read, mem_req_write, mem_req_addr, mem_req_data,
                  input mem_req_ready, mem_rsp_valid, mem_rsp_addr, mem_rsp_data);
  modport slave  (input mem_req_read, mem_req_write, mem_req_addr, mem_req_data,
                  output mem_req_ready, mem_rsp_valid, mem_rsp_addr, mem_rsp_data);
`endif
endinterface

// File: rtl/cpu_main_memory.sv
// cpu_main_memory: single-outstanding line RAM with fixed response latency; optional CPU_MEM_RANGE_CHECK_EN flags out-of-range addresses
module cpu_main_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 4
) (
  input logic clock,
  input logic reset,
  cpu_main_memory_if.slave m
);
  localparam int IW = $clog2(DEPTH_LINES);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic [ADDR_WIDTH-1:0] c_addr, a_addr;
  logic [LINE_WIDTH-1:0] c_data, a_data, r_data;
  logic c_wr, a_wr, idle, accept, access, oor;
  logic [IW-1:0] idx;
  logic [LINE_WIDTH-1:0] ram [DEPTH_LINES];
  assign m.mem_req_ready = state == IDLE;
  assign m.mem_rsp_valid = state == RESP;
  // Access operands come straight from the bus on the acceptance edge (LATENCY=1), else from the capture
  always_comb begin
    idle   = state == IDLE;
    accept = idle && (m.mem_req_read || m.mem_req_write);
    a_addr = (idle ? m.mem_req_addr : c_addr) & ~ADDR_WIDTH'(15);
    a_data = idle ? m.mem_req_data : c_data;
    a_wr   = idle ? m.mem_req_write : c_wr;
    idx    = a_addr[4 +: IW];
    access = (state == BUSY && cnt == '0) || (LATENCY == 1 && accept);
`ifdef CPU_MEM_RANGE_CHECK_EN
    oor    = (a_addr >> (4 + IW)) != '0;
`else
    oor    = 1'b0;
`endif
    r_data = oor ? '0 : a_wr ? a_data : ram[idx];
  end
  // State register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  // Next state: a single response cycle follows the latency countdown
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? (LATENCY == 1 ? RESP : BUSY) : IDLE;
      BUSY:    nxt = cnt == '0 ? RESP : BUSY;
      default: nxt = IDLE;
    endcase
  end
  // Request capture, latency countdown and response registers
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt             <= '0;
      c_addr          <= '0;
      c_data          <= '0;
      c_wr            <= 1'b0;
      m.mem_rsp_addr  <= '0;
      m.mem_rsp_data  <= '0;
`ifdef CPU_MEM_RANGE_CHECK_EN
      m.mem_rsp_error <= 1'b0;
`endif
    end else begin
      if (accept) begin
        cnt    <= 8'(LATENCY - 1);
        c_addr <= a_addr;
        c_data <= a_data;
        c_wr   <= a_wr;
      end else if (state == BUSY && cnt != '0) cnt <= cnt - 8'd1;
      if (access) begin
        m.mem_rsp_addr  <= a_addr;
        m.mem_rsp_data  <= r_data;
`ifdef CPU_MEM_RANGE_CHECK_EN
        m.mem_rsp_error <= oor;
`endif
      end
    end
  // Line array is never cleared; writes only land on the access edge
  always_ff @(posedge clock)
    if (reset && access && a_wr && !oor) ram[idx] <= a_data;
endmodule

// File: tb/tb_cpu_main_memory.sv
// tb_cpu_main_memory: randomized and directed checks of cpu_main_memory against a line-array model
module tb_cpu_main_memory;
  localparam int LAT = 4;
  localparam logic [127:0] D2 = 128'hDDDDDDDDCCCCCCCCBBBBBBBBAAAAAAAA;
  localparam logic [127:0] D4 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  cpu_main_memory_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) m();
  cpu_main_memory #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .DEPTH_LINES(256), .LATENCY(LAT))
    dut (.clock(clock), .reset(reset), .m(m));
  int tests = 0;
  int fails = 0;
  logic [127:0] mdl [256];
  bit known [256];
  logic [127:0] r_data;
  logic [31:0] r_addr;
  logic r_err;
  int r_lat;
  bit r_busy_ok, r_pulse_ok;

  function automatic void model(input bit wr, input logic [31:0] a, input logic [127:0] d,
                                output logic [127:0] ed, output bit ee, output bit kn);
    int i;
    bit o;
    i = int'(a[11:4]);
`ifdef CPU_MEM_RANGE_CHECK_EN
    o = a[31:12] != 0;
`else
    o = 1'b0;
`endif
    ee = o;
    kn = 1'b1;
    if (o) ed = '0;
    else if (wr) begin mdl[i] = d; known[i] = 1'b1; ed = d; end
    else begin ed = mdl[i]; kn = known[i]; end
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [127:0] d);
    @(negedge clock);
    m.mem_req_read = rd; m.mem_req_write = wr; m.mem_req_addr = a; m.mem_req_data = d;
    @(posedge clock); #1;
    m.mem_req_read = 0; m.mem_req_write = 0;
    r_busy_ok = !m.mem_req_ready;
    r_lat = 0;
    while (!m.mem_rsp_valid && r_lat < 300) begin
      @(posedge clock); #1;
      r_lat++;
      if (!m.mem_rsp_valid && m.mem_req_ready) r_busy_ok = 0;
    end
    if (m.mem_req_ready) r_busy_ok = 0;
    r_addr = m.mem_rsp_addr;
    r_data = m.mem_rsp_data;
`ifdef CPU_MEM_RANGE_CHECK_EN
    r_err = m.mem_rsp_error;
`else
    r_err = 1'b0;
`endif
    @(posedge clock); #1;
    r_pulse_ok = !m.mem_rsp_valid && m.mem_req_ready;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (2) @(posedge clock);
    #1;
    tests++; if (m.mem_req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_in got=%b exp=1", m.mem_req_ready); end
    @(negedge clock); reset = 1; #1;
    tests++; if (m.mem_req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", m.mem_req_ready); end
    tests++; if (m.mem_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", m.mem_rsp_valid); end
    tests++; if (m.mem_rsp_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", m.mem_rsp_addr); end
    tests++; if (m.mem_rsp_data !== 128'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", m.mem_rsp_data); end
  endtask

  task automatic test_write();
    logic [127:0] ed; bit ee, kn;
    model(1, 32'h10, D2, ed, ee, kn);
    issue(0, 1, 32'h10, D2);
    tests++; if (r_lat != LAT) begin fails++; $display("FAIL write_latency got=%0d exp=%0d", r_lat, LAT); end
    tests++; if (!r_busy_ok) begin fails++; $display("FAIL write_busy_ready got=1 exp=0"); end
    tests++; if (!r_pulse_ok) begin fails++; $display("FAIL write_pulse_end got=bad exp=valid0_ready1"); end
    tests++; if (r_addr !== 32'h10) begin fails++; $display("FAIL write_addr got=%h exp=10", r_addr); end
    tests++; if (r_data !== ed) begin fails++; $display("FAIL write_data got=%h exp=%h", r_data, ed); end
  endtask

  task automatic test_read_offset();
    issue(1, 0, 32'h1C, '0);
    tests++; if (r_addr !== 32'h10) begin fails++; $display("FAIL read1c_addr got=%h exp=10", r_addr); end
    tests++; if (r_data !== D2) begin fails++; $display("FAIL read1c_data got=%h exp=%h", r_data, D2); end
    issue(1, 0, 32'h14, '0);
    tests++; if (r_data !== D2) begin fails++; $display("FAIL read14_data got=%h exp=%h", r_data, D2); end
    tests++; if (r_lat != LAT) begin fails++; $display("FAIL read_latency got=%0d exp=%0d", r_lat, LAT); end
  endtask

  task automatic test_ignore_busy();
    logic [127:0] ed, cap; bit ee, kn;
    int pulses;
    model(1, 32'h20, D4, ed, ee, kn);
    issue(0, 1, 32'h20, D4);
    @(negedge clock);
    m.mem_req_read = 1; m.mem_req_addr = 32'h20;
    @(posedge clock); #1; m.mem_req_read = 0;
    @(posedge clock); #1; m.mem_req_write = 1; m.mem_req_data = ~D4;
    @(posedge clock); #1; m.mem_req_write = 0;
    pulses = 0; cap = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (m.mem_rsp_valid) begin pulses++; cap = m.mem_rsp_data; end
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL busy_pulses got=%0d exp=1", pulses); end
    tests++; if (cap !== D4) begin fails++; $display("FAIL busy_read_data got=%h exp=%h", cap, D4); end
    issue(1, 0, 32'h20, '0);
    tests++; if (r_data !== D4) begin fails++; $display("FAIL busy_reread got=%h exp=%h", r_data, D4); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge clock);
    m.mem_req_read = 1; m.mem_req_addr = 32'h10;
    @(posedge clock); #1; m.mem_req_read = 0;
    @(posedge clock); @(posedge clock); #1; reset = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clock); #1; if (m.mem_rsp_valid) pulses++; end
    @(negedge clock); reset = 1;
    for (int i = 0; i < 8; i++) begin @(posedge clock); #1; if (m.mem_rsp_valid) pulses++; end
    tests++; if (pulses != 0) begin fails++; $display("FAIL abort_read_pulses got=%0d exp=0", pulses); end
    tests++; if (m.mem_req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got=%b exp=1", m.mem_req_ready); end
    @(negedge clock);
    m.mem_req_write = 1; m.mem_req_addr = 32'h10; m.mem_req_data = ~D2;
    @(posedge clock); #1; m.mem_req_write = 0;
    @(posedge clock); #1; reset = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clock); #1; if (m.mem_rsp_valid) pulses++; end
    @(negedge clock); reset = 1;
    for (int i = 0; i < 8; i++) begin @(posedge clock); #1; if (m.mem_rsp_valid) pulses++; end
    tests++; if (pulses != 0) begin fails++; $display("FAIL abort_write_pulses got=%0d exp=0", pulses); end
    issue(1, 0, 32'h10, '0);
    tests++; if (r_data !== D2) begin fails++; $display("FAIL abort_reread got=%h exp=%h", r_data, D2); end
  endtask

  task automatic test_range();
    logic [127:0] ed; bit ee, kn;
    model(0, 32'h1010, '0, ed, ee, kn);
    issue(1, 0, 32'h1010, '0);
    tests++; if (r_addr !== 32'h1010) begin fails++; $display("FAIL range_addr got=%h exp=1010", r_addr); end
    tests++; if (r_data !== ed) begin fails++; $display("FAIL range_data got=%h exp=%h", r_data, ed); end
`ifdef CPU_MEM_RANGE_CHECK_EN
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL range_error got=%b exp=1", r_err); end
`endif
  endtask

  task automatic test_random();
    logic [127:0] ed, d; logic [31:0] a; bit ee, kn, rd, wr;
    int op;
    for (int i = 0; i < 256; i++) begin
      a = {20'h0, 8'(i), 4'($urandom)};
      d = {$urandom, $urandom, $urandom, $urandom};
      model(1, a, d, ed, ee, kn);
      issue(0, 1, a, d);
      tests++; if (r_data !== ed || r_addr !== {a[31:4], 4'h0}) begin fails++; $display("FAIL fill_%0d got=%h/%h exp=%h/%h", i, r_addr, r_data, {a[31:4], 4'h0}, ed); end
    end
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[31:12] = 20'h0;
      d = {$urandom, $urandom, $urandom, $urandom};
      op = $urandom_range(2);
      rd = op != 1; wr = op != 0;
      model(wr, a, d, ed, ee, kn);
      issue(rd, wr, a, d);
      tests++; if (r_lat != LAT || !r_busy_ok || !r_pulse_ok) begin fails++; $display("FAIL rand_timing_%0d got=lat%0d busy%0d pulse%0d exp=lat%0d", i, r_lat, r_busy_ok, r_pulse_ok, LAT); end
      tests++; if (r_addr !== {a[31:4], 4'h0}) begin fails++; $display("FAIL rand_addr_%0d got=%h exp=%h", i, r_addr, {a[31:4], 4'h0}); end
      if (kn) begin
        tests++; if (r_data !== ed) begin fails++; $display("FAIL rand_data_%0d got=%h exp=%h", i, r_data, ed); end
      end
`ifdef CPU_MEM_RANGE_CHECK_EN
      tests++; if (r_err !== ee) begin fails++; $display("FAIL rand_err_%0d got=%b exp=%b", i, r_err, ee); end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) known[i] = 1'b0;
    m.mem_req_read = 0; m.mem_req_write = 0; m.mem_req_addr = '0; m.mem_req_data = '0;
    test_reset();
    test_write();
    test_read_offset();
    test_ignore_busy();
    test_reset_abort();
    test_range();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
